apb_regbank_slave: RTL

//  Parametrised APB4 completer: a bank of NUM_REGS DATA-bit registers with byte strobes,

---
 rtl/apb_regbank_slave.sv | 102 ++++++++++
 1 files changed

// File: rtl/apb_regbank_slave.sv
// apb_regbank_slave: APB4 register bank with byte strobes, programmable wait states, pslverr and sticky protocol-error flag
module apb_regbank_slave #(
  parameter int ADDR = 32,
  parameter int DATA = 32,
  parameter int NUM_REGS = 16,
  parameter int BASE_ADDR = 0,
  parameter int PRIV_REGS = 1,
  parameter logic [DATA-1:0] RESET_VAL = '0
) (
  input  logic                     system_clock,
  input  logic                     reset,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [ADDR-1:0]          paddr,
  input  logic [DATA-1:0]          pwdata,
  input  logic [DATA/8-1:0]        pstrb,
  input  logic [2:0]               pprot,
  input  logic [3:0]               wait_cfg,
  output logic [DATA-1:0]          prdata,
  output logic                     pready,
  output logic                     pslverr,
  output logic                     prot_err,
  output logic [NUM_REGS*DATA-1:0] reg_q
);
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR-1:0] BA = ADDR'(BASE_ADDR);
  localparam logic [ADDR-1:0] NR = ADDR'(NUM_REGS);
  localparam logic [ADDR-1:0] PR = ADDR'(PRIV_REGS);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [ADDR-1:0] a_addr, d_addr, off;
  logic [DATA-1:0] a_wdata, rd_val;
  logic [DATA/8-1:0] a_strb;
  logic a_write, a_prot, d_write, d_prot, dec_err, violation;
  logic [IW-1:0] dec_idx;
  logic [DATA-1:0] regs [NUM_REGS];
  logic unused_prot;
  assign unused_prot = ^pprot[2:1];
  // Decode the live bus during setup and the latched request during access.
  always_comb begin
    d_addr = state == ACCESS ? a_addr : paddr;
    d_write = state == ACCESS ? a_write : pwrite;
    d_prot = state == ACCESS ? a_prot : pprot[0];
    off = d_addr - BA;
    dec_err = (|d_addr[1:0]) || d_addr < BA || (off >> 2) >= NR || ((off >> 2) < PR && !d_prot);
    dec_idx = IW'(off >> 2);
    rd_val = (dec_err || d_write) ? '0 : regs[dec_idx];
    violation = state == IDLE ? penable
              : ((!pready && !psel) || paddr != a_addr || pwrite != a_write || pwdata != a_wdata);
  end
  always_ff @(posedge system_clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      pready <= 1'b0;
      pslverr <= 1'b0;
      prdata <= '0;
      prot_err <= 1'b0;
      a_addr <= '0;
      a_write <= 1'b0;
      a_wdata <= '0;
      a_strb <= '0;
      a_prot <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else if (violation) begin
      prot_err <= 1'b1;
      state <= IDLE;
      pready <= 1'b0;
      pslverr <= 1'b0;
      prdata <= '0;
    end else if (state == IDLE) begin
      if (psel) begin
        state <= ACCESS;
        a_addr <= paddr;
        a_write <= pwrite;
        a_wdata <= pwdata;
        a_strb <= pstrb;
        a_prot <= pprot[0];
        cnt <= wait_cfg;
        pready <= wait_cfg == 4'd0;
        pslverr <= wait_cfg == 4'd0 && dec_err;
        prdata <= wait_cfg == 4'd0 ? rd_val : '0;
      end
    end else if (pready) begin
      state <= IDLE;
      pready <= 1'b0;
      pslverr <= 1'b0;
      prdata <= '0;
      if (a_write && !dec_err)
        for (int b = 0; b < DATA/8; b++)
          if (a_strb[b]) regs[dec_idx][b*8 +: 8] <= a_wdata[b*8 +: 8];
    end else begin
      cnt <= cnt - 4'd1;
      pready <= cnt == 4'd1;
      pslverr <= cnt == 4'd1 && dec_err;
      prdata <= cnt == 4'd1 ? rd_val : '0;
    end
  end
  for (genvar g = 0; g < NUM_REGS; g++) assign reg_q[g*DATA +: DATA] = regs[g];
endmodule
